// File: rtl/fifo_rptr_empty.sv
// Read-side pointer, empty and sticky underflow logic for the async FIFO.
// Define FIFO_RD_LEVEL_EN to add the rlevel / raempty outputs.
module fifo_rptr_empty #(
  parameter int ADDRSIZE      = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                runderflow
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                raempty
`endif
);

  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbinnext;
  logic [ADDRSIZE:0] rgraynext;
  logic              rd_ok;

  assign rd_ok     = rinc & ~rempty;
  assign rbinnext  = rbin + {{ADDRSIZE{1'b0}}, rd_ok};
  assign rgraynext = (rbinnext >> 1) ^ rbinnext;
  assign raddr     = rbin[ADDRSIZE-1:0];

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin       <= '0;
      rptr       <= '0;
      rempty     <= 1'b1;
      runderflow <= 1'b0;
    end else begin
      rbin   <= rbinnext;
      rptr   <= rgraynext;
      rempty <= (rgraynext == rq2_wptr);
      if (rinc & rempty)
        runderflow <= 1'b1;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  localparam logic [ADDRSIZE:0] THRESH =
    (ADDRSIZE+1)'(AEMPTY_THRESH);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] lvl_next;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++)
      wbin[i] = ^(rq2_wptr >> i);
  end

  assign lvl_next = wbin - rbinnext;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rlevel  <= '0;
      raempty <= 1'b1;
    end else begin
      rlevel  <= lvl_next;
      raempty <= (lvl_next <= THRESH);
    end
  end
`endif

endmodule

// File: doc/fifo_rptr_empty.md
# fifo_rptr_empty

Read-domain pointer and empty-flag generator for the asynchronous FIFO. Consumes the write pointer already synchronized into the read clock domain (Gray, ADDRSIZE+1 bits), maintains the binary and Gray read pointers, and drives the FIFO memory read address. It also produces a registered empty flag and a sticky underflow flag. Its Gray read pointer feeds the read-to-write synchronizer.

## Interface
Parameters:
- ADDRSIZE, 4, memory address width; depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
- AEMPTY_THRESH, 2, raempty asserts when level <= this value. Only used with FIFO_RD_LEVEL_EN.

Ports:
- rclk  in  1  read clock; all state on rising edge.
- rrst  in  1  reset, asynchronous and active-high; one clock (rclk), no other reset.
- rinc  in  1  read request from consumer.
- rq2_wptr  in  ADDRSIZE+1  synchronized Gray write pointer.
- raddr  out  ADDRSIZE  memory read address.
- rptr  out  ADDRSIZE+1  registered Gray read pointer, to the read-to-write synchronizer.
- rempty  out  1  registered empty flag.
- runderflow  out  1  sticky: read attempted while empty.
- rlevel  out  ADDRSIZE+1  registered fill level as seen by the read side. Present only with FIFO_RD_LEVEL_EN.
- raempty  out  1  registered almost-empty flag. Present only with FIFO_RD_LEVEL_EN.

## Operation
- State: rbin (binary, ADDRSIZE+1), rptr (Gray), rempty, runderflow; plus rlevel and raempty when enabled.
- Read acceptance: rd_ok = rinc & ~rempty.
- Next binary pointer: rbinnext = rbin + rd_ok, modulo 2^(ADDRSIZE+1).
- Next Gray pointer: rgraynext = (rbinnext >> 1) ^ rbinnext.
- Register updates each edge:
  - rbin <= rbinnext
  - rptr <= rgraynext
  - rempty <= (rgraynext == rq2_wptr)
- raddr = rbin[ADDRSIZE-1:0]. This is a combinational slice of the register, with no added latency.
- Underflow: if rinc & rempty, then runderflow <= 1. It clears only on reset.
  - A read while empty does not move any pointer.
- rptr changes by at most one bit per cycle. Only registered Gray values leave the block; no glitching combinational path drives rptr.
- Wrap-around: rbin rolls from 2^(ADDRSIZE+1)-1 to 0.
  - The MSB of rbin/rptr is the wrap bit.
  - Empty means all ADDRSIZE+1 Gray bits are equal.
- Reset values (applied immediately on rrst rise, held while high):
  - rbin = 0, rptr = 0, raddr = 0
  - rempty = 1, runderflow = 0
  - rlevel = 0, raempty = 1
- Reset mid-operation discards all state. The first edge after rrst falls behaves as from power-up.

## Timing
- Read latency: a read accepted at edge N updates raddr, rptr and rempty at edge N.
- Going empty: rempty asserts on the same edge that accepts the last read. There is no extra cycle in which a spurious read can be accepted.
- Going non-empty: a change on rq2_wptr clears rempty at the next rclk edge. This is one cycle after the synchronizer output changes, and 3 rclk edges after the write-domain pointer changes.
- Simultaneous rinc and a rq2_wptr advance: both take effect in the same edge's compare.
- Empty is pessimistic: it may stay asserted up to the synchronizer delay after data exists. It never deasserts falsely.

## Configuration
- Macro: FIFO_RD_LEVEL_EN.
- When defined, the block adds three things:
  - A Gray-to-binary converter on rq2_wptr, giving wbin.
  - rlevel <= (wbin - rbinnext) modulo 2^(ADDRSIZE+1). Range is 0..2^ADDRSIZE.
  - raempty <= (that value <= AEMPTY_THRESH).
- When undefined, the rlevel and raempty ports and all of their logic are absent. All other behaviour is identical.

## Test plan
- Reset: assert rrst mid-clock with rq2_wptr=5'b00000.
  - Immediately: rempty=1, rptr=0, raddr=0, runderflow=0, rlevel=0, raempty=1.
- Single entry: after reset, drive rq2_wptr=5'b00001.
  - Next edge: rempty=0, rlevel=1, raempty=1.
  - Pulse rinc one cycle: at that edge raddr=1, rptr=5'b00001, rempty=1, rlevel=0.
- Underflow: with rempty=1, hold rinc for 2 cycles.
  - runderflow=1 and stays 1; rptr and raddr unchanged.
  - Only rrst clears runderflow.
- Full level: step rq2_wptr through Gray counts 1..16 with no reads.
  - rlevel reaches 16 and raempty=0.
  - Then read 14: raempty asserts when rlevel=2.
- Wrap-around: run 32 write/read pairs.
  - rptr steps through the Gray sequence, including 5'b10000 -> 5'b00000 at the rbin 31->0 rollover.
  - raddr wraps 15->0 twice.
  - Each step of rptr flips exactly one bit.
  - rempty=1 after each paired read.
- Simultaneous events: with 1 entry stored, assert rinc while rq2_wptr advances by one in the same cycle.
  - Result: rempty=0, rlevel=1, rptr advanced by 1.
